// File: rtl/impor_sched_pkg.sv
// impor_sched shared types and constants.
// States, engine op codes, grid geometry.
package impor_sched_pkg;

  localparam int NPIX  = 9;
  localparam int PIX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_RDY,
    LOAD,
    OPS,
    DRAIN,
    COLLECT,
    DONE
  } state_e;

  localparam logic [PIX_W-1:0] OP_END     = 3'd0;
  localparam logic [PIX_W-1:0] OP_HFLIP   = 3'd1;
  localparam logic [PIX_W-1:0] OP_VFLIP   = 3'd2;
  localparam logic [PIX_W-1:0] OP_ROT_CCW = 3'd3;
  localparam logic [PIX_W-1:0] OP_ROT_CW  = 3'd4;
  localparam logic [PIX_W-1:0] OP_INC_C0  = 3'd5;
  localparam logic [PIX_W-1:0] OP_INC_C1  = 3'd6;
  localparam logic [PIX_W-1:0] OP_INC_C2  = 3'd7;

  function automatic logic op_valid(
    input logic [PIX_W-1:0] c
  );
    return c inside {
      OP_HFLIP, OP_VFLIP, OP_ROT_CCW, OP_ROT_CW,
      OP_INC_C0, OP_INC_C1, OP_INC_C2
    };
  endfunction

endpackage

// File: rtl/impor_rr_arb.sv
// impor_rr_arb: 2-way round-robin arbiter.
// pointer names the requester favoured on contention.
module impor_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt,
  output logic       pointer
);

  // lone requester wins, contention goes to pointer
  always_comb begin
    gnt = req;
    if (&req) gnt = pointer ? 2'b10 : 2'b01;
  end

  // move pointer past the winner on each grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pointer <= 1'b0;
    else if (advance) pointer <= gnt[0];
  end

endmodule

// File: rtl/impor_sched.sv
// impor_sched: job scheduler for the 3x3 engine.
// Optional watchdog: define IMPOR_SCHED_WDOG_EN.
module impor_sched
  import impor_sched_pkg::*;
#(
  parameter int MAX_OPS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [NPIX*PIX_W-1:0]   req_pix0,
  input  logic [NPIX*PIX_W-1:0]   req_pix1,
  input  logic [MAX_OPS*PIX_W-1:0] req_ops0,
  input  logic [MAX_OPS*PIX_W-1:0] req_ops1,
  output logic [PIX_W-1:0]        eng_in,
  output logic                    eng_in_valid,
  output logic [PIX_W-1:0]        eng_mode,
  input  logic                    eng_ready,
  input  logic [PIX_W-1:0]        eng_out,
  input  logic                    eng_out_valid,
  output logic                    res_valid,
  output logic                    res_id,
  output logic [NPIX*PIX_W-1:0]   res_pix,
  output logic                    res_err,
  output logic                    busy
);

  localparam int OPW = $clog2(MAX_OPS);
  localparam int GW  = NPIX * PIX_W;

  state_e                     state;
  logic [GW-1:0]              pix_q;
  logic [MAX_OPS*PIX_W-1:0]   ops_q;
  logic [GW-1:0]              rbuf;
  logic [GW-1:0]              rnext;
  logic [3:0]                 idx;
  logic [3:0]                 nidx;
  logic [OPW-1:0]             opi;
  logic [OPW-1:0]             nop;
  logic [PIX_W-1:0]           nxt_op;
  logic [1:0]                 gnt;
  logic                       ptr;
  logic                       advance;
  logic                       wdog_hit;

  assign advance = (state == IDLE) && |req_valid;
  assign nidx    = idx + 4'd1;
  assign nop     = opi + 1'b1;
  assign nxt_op  = ops_q[nop*PIX_W +: PIX_W];

  impor_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt),
    .pointer (ptr)
  );

  // result grid with the incoming pixel merged at idx
  always_comb begin
    rnext = rbuf;
    rnext[idx*PIX_W +: PIX_W] = eng_out;
  end

`ifdef IMPOR_SCHED_WDOG_EN
  logic [5:0] wdog;
  logic       stay;

  assign stay = ((state == WAIT_RDY) && !eng_ready) ||
                (((state == DRAIN) || (state == COLLECT)) &&
                 !eng_out_valid);
  assign wdog_hit = stay && (wdog == 6'd62);

  // idle-wait counter; any progress or state change clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog <= '0;
    else if (stay && !wdog_hit) wdog <= wdog + 6'd1;
    else wdog <= '0;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  // job sequencer; pointer sits past the winner, so ~ptr is the job id
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      req_ready    <= '0;
      pix_q        <= '0;
      ops_q        <= '0;
      rbuf         <= '0;
      idx          <= '0;
      opi          <= '0;
      eng_in       <= '0;
      eng_in_valid <= 1'b0;
      eng_mode     <= OP_END;
      res_valid    <= 1'b0;
      res_id       <= 1'b0;
      res_pix      <= '0;
      res_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      req_ready <= '0;
      res_valid <= 1'b0;
      if (wdog_hit) begin
        state     <= DONE;
        res_valid <= 1'b1;
        res_pix   <= '0;
        res_err   <= 1'b1;
        res_id    <= ~ptr;
      end else begin
        unique case (state)
          IDLE: begin
            if (|req_valid) begin
              req_ready <= gnt;
              pix_q     <= gnt[1] ? req_pix1 : req_pix0;
              ops_q     <= gnt[1] ? req_ops1 : req_ops0;
              busy      <= 1'b1;
              state     <= WAIT_RDY;
            end
          end
          WAIT_RDY: begin
            if (eng_ready) begin
              eng_in_valid <= 1'b1;
              eng_in       <= pix_q[PIX_W-1:0];
              idx          <= '0;
              state        <= LOAD;
            end
          end
          LOAD: begin
            if (idx == 4'(NPIX-1)) begin
              eng_in_valid <= 1'b0;
              eng_in       <= '0;
              idx          <= '0;
              opi          <= '0;
              if (op_valid(ops_q[PIX_W-1:0])) begin
                eng_mode <= ops_q[PIX_W-1:0];
                state    <= OPS;
              end else begin
                state <= DRAIN;
              end
            end else begin
              idx    <= nidx;
              eng_in <= pix_q[nidx*PIX_W +: PIX_W];
            end
          end
          OPS: begin
            if (int'(opi) == MAX_OPS-1 ||
                !op_valid(nxt_op)) begin
              eng_mode <= OP_END;
              state    <= DRAIN;
            end else begin
              opi      <= nop;
              eng_mode <= nxt_op;
            end
          end
          DRAIN, COLLECT: begin
            if (eng_out_valid) begin
              rbuf <= rnext;
              idx  <= nidx;
              if (idx == 4'(NPIX-1)) begin
                state     <= DONE;
                res_valid <= 1'b1;
                res_pix   <= rnext;
                res_err   <= 1'b0;
                res_id    <= ~ptr;
              end else begin
                state <= COLLECT;
              end
            end
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_impor_sched.sv
// tb_impor_sched: scoreboard bench with model engine.
// Watchdog case runs when IMPOR_SCHED_WDOG_EN is defined.
module tb_impor_sched;

  typedef struct {
    logic [26:0] pix;
    logic [23:0] ops;
  } job_t;

  typedef struct {
    logic        id;
    logic [26:0] pix;
    logic        err;
  } res_t;

  typedef struct {
    logic [23:0] ops;
    int          cnt;
  } opx_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [26:0] req_pix0, req_pix1;
  logic [23:0] req_ops0, req_ops1;
  logic [2:0]  eng_in;
  logic        eng_in_valid;
  logic [2:0]  eng_mode;
  logic        eng_ready;
  logic [2:0]  eng_out;
  logic        eng_out_valid;
  logic        res_valid;
  logic        res_id;
  logic [26:0] res_pix;
  logic        res_err;
  logic        busy;

  impor_sched dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_pix0      (req_pix0),
    .req_pix1      (req_pix1),
    .req_ops0      (req_ops0),
    .req_ops1      (req_ops1),
    .eng_in        (eng_in),
    .eng_in_valid  (eng_in_valid),
    .eng_mode      (eng_mode),
    .eng_ready     (eng_ready),
    .eng_out       (eng_out),
    .eng_out_valid (eng_out_valid),
    .res_valid     (res_valid),
    .res_id        (res_id),
    .res_pix       (res_pix),
    .res_err       (res_err),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  job_t jq0[$];
  job_t jq1[$];
  res_t sb[$];
  opx_t oq[$];

  int          last_w = 1;
  int          acc_cyc = 0;
  int          res_cyc = 0;
  int          nres = 0;
  logic [26:0] last_pix = '0;
  bit          rdy_en = 1'b1;
  bit          gap_mode = 1'b0;
  bit          rnd_gaps = 1'b0;
  bit          wd_mode = 1'b0;

  // one engine operation on a row-major 3x3 grid
  function automatic logic [26:0] apply_op(
    input logic [26:0] g,
    input logic [2:0]  op
  );
    logic [26:0] o;
    int r, c, s;
    o = g;
    for (int k = 0; k < 9; k++) begin
      r = k / 3;
      c = k % 3;
      case (op)
        3'd1:    s = r * 3 + (2 - c);
        3'd2:    s = (2 - r) * 3 + c;
        3'd3:    s = c * 3 + (2 - r);
        3'd4:    s = (2 - c) * 3 + r;
        default: s = k;
      endcase
      o[3*k +: 3] = g[3*s +: 3];
      if (int'(op) >= 5 && c == int'(op) - 5 &&
          g[3*k +: 3] != 3'd7)
        o[3*k +: 3] = g[3*k +: 3] + 3'd1;
    end
    return o;
  endfunction

  // op list as issued: up to the first zero, at most 8
  function automatic opx_t trim(input logic [23:0] ops);
    opx_t x;
    x.ops = '0;
    x.cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (ops[3*i +: 3] == 3'd0) break;
      x.ops[3*i +: 3] = ops[3*i +: 3];
      x.cnt++;
    end
    return x;
  endfunction

  function automatic logic [26:0] ref_result(input job_t j);
    opx_t x;
    logic [26:0] g;
    x = trim(j.ops);
    g = j.pix;
    for (int i = 0; i < x.cnt; i++)
      g = apply_op(g, x.ops[3*i +: 3]);
    return g;
  endfunction

  function automatic job_t rand_job();
    job_t j;
    int len;
    j.pix = 27'($urandom);
    j.ops = '0;
    len = $urandom_range(0, 8);
    for (int i = 0; i < 8; i++) begin
      if (i < len)
        j.ops[3*i +: 3] = 3'($urandom_range(1, 7));
      else if (i > len)
        j.ops[3*i +: 3] = 3'($urandom_range(0, 7));
    end
    return j;
  endfunction

  // requester driver and grant checker
  initial begin : driver
    int   pred;
    job_t j;
    res_t e;
    req_valid = '0;
    req_pix0 = '0;
    req_pix1 = '0;
    req_ops0 = '0;
    req_ops1 = '0;
    forever begin
      @(negedge clk);
      req_valid[0] = jq0.size() > 0;
      req_valid[1] = jq1.size() > 0;
      if (jq0.size() > 0) begin
        req_pix0 = jq0[0].pix;
        req_ops0 = jq0[0].ops;
      end
      if (jq1.size() > 0) begin
        req_pix1 = jq1[0].pix;
        req_ops1 = jq1[0].ops;
      end
      @(posedge clk);
      #1;
      if (req_ready != 2'b00) begin
        checks++;
        if (req_valid == 2'b00) begin
          errors++;
          $display("FAIL accept_spurious got %b want 00",
                   req_ready);
        end else begin
          if (req_valid == 2'b11)
            pred = (last_w == 0) ? 1 : 0;
          else
            pred = req_valid[0] ? 0 : 1;
          if (req_ready != (2'b01 << pred)) begin
            errors++;
            $display("FAIL grant got %b want %b",
                     req_ready, 2'b01 << pred);
          end
          j = (pred == 1) ? jq1.pop_front()
                          : jq0.pop_front();
          last_w = pred;
          acc_cyc = cyc;
          oq.push_back(trim(j.ops));
          e.id  = (pred == 1);
          e.pix = wd_mode ? 27'd0 : ref_result(j);
          e.err = wd_mode;
          sb.push_back(e);
        end
      end
    end
  end

  // result monitor
  initial begin : monitor
    res_t e;
    forever begin
      @(posedge clk);
      #1;
      if (res_valid) begin
        checks++;
        nres++;
        res_cyc  = cyc;
        last_pix = res_pix;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL res_unexpected got id=%0d pix=%o",
                   res_id, res_pix);
        end else begin
          e = sb.pop_front();
          if (res_id !== e.id || res_pix !== e.pix ||
              res_err !== e.err) begin
            errors++;
            $display("FAIL result got id=%0d pix=%o err=%0d want id=%0d pix=%o err=%0d",
                     res_id, res_pix, res_err,
                     e.id, e.pix, e.err);
          end
        end
      end
    end
  end

  // behavioural engine: load grid, gather ops, stream result
  initial begin : engine
    int          es, n, m, k, dly, gap;
    logic [26:0] g, r;
    logic [23:0] seen;
    opx_t        x;
    es = 0; n = 0; m = 0; k = 0; dly = 0; gap = 0;
    g = '0; r = '0; seen = '0;
    eng_ready = 1'b0;
    eng_out = '0;
    eng_out_valid = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        es = 0;
        n = 0;
        eng_ready = 1'b0;
        eng_out = '0;
        eng_out_valid = 1'b0;
        continue;
      end
      if (es == 0) begin
        eng_ready = rdy_en;
        if (eng_in_valid) begin
          g[3*n +: 3] = eng_in;
          n++;
          if (n == 9) begin
            es = 1;
            m = 0;
            seen = '0;
            eng_ready = 1'b0;
          end
        end
      end else if (es == 1) begin
        if (eng_mode != 3'd0) begin
          if (m < 8) seen[3*m +: 3] = eng_mode;
          m++;
        end else begin
          checks++;
          if (oq.size() == 0) begin
            errors++;
            $display("FAIL ops_unexpected got cnt=%0d want none",
                     m);
          end else begin
            x = oq.pop_front();
            if (m != x.cnt || seen !== x.ops) begin
              errors++;
              $display("FAIL ops got cnt=%0d ops=%o want cnt=%0d ops=%o",
                       m, seen, x.cnt, x.ops);
            end
          end
          r = g;
          for (int i = 0; i < m && i < 8; i++)
            r = apply_op(r, seen[3*i +: 3]);
          es = 2;
          k = 0;
          gap = 0;
          dly = $urandom_range(0, 3);
        end
      end
      if (es == 2) begin
        if (dly > 0) begin
          dly--;
          eng_out_valid = 1'b0;
        end else if (k == 9) begin
          eng_out_valid = 1'b0;
          eng_out = '0;
          es = 0;
          n = 0;
        end else if (gap > 0) begin
          gap--;
          eng_out_valid = 1'b0;
        end else begin
          eng_out = r[3*k +: 3];
          eng_out_valid = 1'b1;
          k++;
          if (gap_mode && k == 5)
            gap = 2;
          else if (rnd_gaps && $urandom_range(0, 3) == 0)
            gap = 1;
        end
      end
    end
  end

  task automatic check_zero(input string name);
    logic [39:0] v;
    v = {req_ready, eng_in, eng_in_valid, eng_mode,
         res_valid, res_id, res_pix, res_err, busy};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s got %h want 0", name, v);
    end
  endtask

  task automatic check_pix(
    input string       name,
    input logic [26:0] want
  );
    checks++;
    if (last_pix !== want) begin
      errors++;
      $display("FAIL %s got %o want %o",
               name, last_pix, want);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (jq0.size() + jq1.size() + sb.size() != 0 ||
           busy) begin
      @(posedge clk);
      #1;
      t++;
      if (t > 4000) begin
        checks++;
        errors++;
        $display("FAIL timeout got pending=%0d want 0",
                 jq0.size() + jq1.size() + sb.size());
        jq0.delete();
        jq1.delete();
        sb.delete();
        oq.delete();
        return;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : main
    job_t j;
    int   t;
    int   n0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // basic HFLIP job
    for (int k = 0; k < 9; k++) j.pix[3*k +: 3] = 3'(k % 8);
    j.ops = 24'd1;
    jq0.push_back(j);
    wait_idle();
    check_pix("basic_pix", 27'o670345012);

    // empty op list
    j.pix = 27'o123456701;
    j.ops = 24'o00000000;
    jq0.push_back(j);
    wait_idle();
    check_pix("empty_ops_pix", 27'o123456701);

    // lone requester 1, then contention for 4 jobs
    jq1.push_back(rand_job());
    wait_idle();
    for (int i = 0; i < 2; i++) begin
      jq0.push_back(rand_job());
      jq1.push_back(rand_job());
    end
    wait_idle();

    // full op list saturating column 0
    j.pix = 27'o666666666;
    j.ops = 24'o55555555;
    jq1.push_back(j);
    wait_idle();
    check_pix("full_ops_pix", 27'o667667667);

    // gapped engine output
    gap_mode = 1'b1;
    jq0.push_back(rand_job());
    wait_idle();
    gap_mode = 1'b0;

    // randomized traffic
    rnd_gaps = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1)
        jq1.push_back(rand_job());
      else
        jq0.push_back(rand_job());
    end
    wait_idle();
    rnd_gaps = 1'b0;

`ifdef IMPOR_SCHED_WDOG_EN
    // engine never ready: watchdog abort
    rdy_en = 1'b0;
    repeat (3) @(posedge clk);
    wd_mode = 1'b1;
    jq0.push_back(rand_job());
    wait_idle();
    wd_mode = 1'b0;
    checks++;
    if (res_cyc - acc_cyc != 63) begin
      errors++;
      $display("FAIL wdog_latency got %0d want 63",
               res_cyc - acc_cyc);
    end
    if (oq.size() > 0) void'(oq.pop_back());
    rdy_en = 1'b1;
    repeat (3) @(posedge clk);
`endif

    // asynchronous reset in the middle of LOAD
    jq0.push_back(rand_job());
    t = 0;
    while (!eng_in_valid && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    checks++;
    if (!eng_in_valid) begin
      errors++;
      $display("FAIL load_start got 0 want 1");
    end
    @(posedge clk);
    #3;
    n0 = nres;
    rst_n = 1'b0;
    #1;
    check_zero("reset_midload");
    sb.delete();
    oq.delete();
    last_w = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (nres != n0) begin
      errors++;
      $display("FAIL reset_discard got %0d want %0d",
               nres, n0);
    end

    // pointer back at requester 0 after reset
    jq0.push_back(rand_job());
    jq1.push_back(rand_job());
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
